// File: rtl/disp_pkg.sv
// disp_pkg: shared digit, source and arbiter state types for the display path
package disp_pkg;
  typedef logic [5:0] digit_t;
  localparam int DIG_EN_BIT = 5;
  typedef enum logic [1:0] {SRC_TIME = 2'd0, SRC_EDIT = 2'd1, SRC_ALARM = 2'd2} src_e;
  typedef enum logic [2:0] {S_SRC0, S_SRC1, S_HOLD1, S_SRC2, S_HOLD2} arb_state_e;
endpackage

// File: rtl/disp_arbiter.sv
// disp_arbiter: priority-shares the 8-digit display among three sources with hold and blink
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int HOLD_TICKS = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pulse_500ms,
  input  logic [2:0]  req,
  input  logic [47:0] src0_d,
  input  logic [47:0] src1_d,
  input  logic [47:0] src2_d,
  input  logic [7:0]  src0_blink,
  input  logic [7:0]  src1_blink,
  input  logic [7:0]  src2_blink,
  output logic [5:0]  d1,
  output logic [5:0]  d2,
  output logic [5:0]  d3,
  output logic [5:0]  d4,
  output logic [5:0]  d5,
  output logic [5:0]  d6,
  output logic [5:0]  d7,
  output logic [5:0]  d8,
  output logic [1:0]  grant,
  output logic        switch_p
);
  arb_state_e st, st_nxt;
  src_e g_nxt;
  logic [3:0] hold_cnt, cnt_nxt;
  logic blink_on, blink_nxt, expire, in_hold, to_hold, unused_req0;
  logic [47:0] sel_d;
  logic [7:0] sel_b;
  digit_t [7:0] d_q, d_nxt;
  assign unused_req0 = req[0];
  assign expire = pulse_500ms && hold_cnt == 4'd1;
  always_comb begin
    st_nxt = S_SRC0;
    case (st)
      S_SRC0:  st_nxt = req[2] ? S_SRC2 : req[1] ? S_SRC1 : S_SRC0;
      S_SRC1:  st_nxt = req[2] ? S_SRC2 : req[1] ? S_SRC1 : S_HOLD1;
      S_HOLD1: st_nxt = req[2] ? S_SRC2 : req[1] ? S_SRC1 : expire ? S_SRC0 : S_HOLD1;
      S_SRC2:  st_nxt = req[2] ? S_SRC2 : S_HOLD2;
      S_HOLD2: st_nxt = req[2] ? S_SRC2 : !expire ? S_HOLD2 : req[1] ? S_SRC1 : S_SRC0;
      default: st_nxt = S_SRC0;
    endcase
  end
  assign in_hold = st == S_HOLD1 || st == S_HOLD2;
  assign to_hold = st_nxt == S_HOLD1 || st_nxt == S_HOLD2;
  assign cnt_nxt = !to_hold ? 4'd0 : !in_hold ? 4'(HOLD_TICKS) : pulse_500ms ? hold_cnt - 4'd1 : hold_cnt;
  assign g_nxt = st_nxt == S_SRC0 ? SRC_TIME :
                 (st_nxt == S_SRC1 || st_nxt == S_HOLD1) ? SRC_EDIT : SRC_ALARM;
  assign blink_nxt = (2'(g_nxt) != grant) ? 1'b1 : blink_on ^ pulse_500ms;
  assign sel_d = g_nxt == SRC_ALARM ? src2_d : g_nxt == SRC_EDIT ? src1_d : src0_d;
  assign sel_b = g_nxt == SRC_ALARM ? src2_blink : g_nxt == SRC_EDIT ? src1_blink : src0_blink;
  always_comb begin
    d_nxt = '0;
    for (int i = 0; i < 8; i++) begin
      d_nxt[i] = sel_d[6*i +: 6];
      d_nxt[i][DIG_EN_BIT] = sel_d[6*i + DIG_EN_BIT] & (blink_nxt | ~sel_b[i]);
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      st <= S_SRC0;
      hold_cnt <= 4'd0;
      blink_on <= 1'b1;
      grant <= 2'd0;
      switch_p <= 1'b0;
      d_q <= '0;
    end else begin
      st <= st_nxt;
      hold_cnt <= cnt_nxt;
      blink_on <= blink_nxt;
      grant <= 2'(g_nxt);
      switch_p <= 2'(g_nxt) != grant;
      d_q <= d_nxt;
    end
  assign {d8, d7, d6, d5, d4, d3, d2, d1} = d_q;
endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: directed scoreboard bench for disp_arbiter with HOLD_TICKS = 3
module tb_disp_arbiter;
  localparam logic [47:0] A  = {8{6'b100010}};
  localparam logic [47:0] B  = {8{6'b101000}};
  localparam logic [47:0] C  = {8{6'b110000}};
  localparam logic [47:0] CB = {8{6'b010000}};
  localparam logic [47:0] E  = {8{6'b100110}};
  localparam logic [47:0] EB = {{6{6'b100110}}, 6'b000110, 6'b000110};
  logic clock = 1'b0, reset = 1'b0, pulse_500ms = 1'b0;
  logic [2:0] req = 3'b000;
  logic [47:0] src0_d = A, src1_d = B, src2_d = C;
  logic [7:0] src0_blink = 8'h00, src1_blink = 8'h00, src2_blink = 8'h00;
  logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
  logic [1:0] grant;
  logic switch_p;
  logic [47:0] dout;
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {
    int cyc;
    logic [1:0] g;
    logic sw;
    logic [47:0] d;
    string name;
  } exp_t;
  exp_t q[$];
  disp_arbiter #(.HOLD_TICKS(3)) dut (
    .clock(clock), .reset(reset), .pulse_500ms(pulse_500ms), .req(req),
    .src0_d(src0_d), .src1_d(src1_d), .src2_d(src2_d),
    .src0_blink(src0_blink), .src1_blink(src1_blink), .src2_blink(src2_blink),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8),
    .grant(grant), .switch_p(switch_p)
  );
  assign dout = {d8, d7, d6, d5, d4, d3, d2, d1};
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      tests++;
      if (e.cyc != cyc || grant !== e.g || switch_p !== e.sw || dout !== e.d) begin
        fails++;
        $display("FAIL %s @cyc %0d: got grant=%0d sw=%0b d=%h, expected grant=%0d sw=%0b d=%h (due cyc %0d)",
                 e.name, cyc, grant, switch_p, dout, e.g, e.sw, e.d, e.cyc);
      end
    end
  end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic push_now(input logic [1:0] g, input logic sw, input logic [47:0] d, input string name);
    q.push_back('{cyc, g, sw, d, name});
  endtask
  task automatic run(input logic [1:0] g, input logic sw, input logic [47:0] d, input string name);
    q.push_back('{cyc + 1, g, sw, d, name});
    step();
  endtask
  initial begin
    step();
    step();
    push_now(2'd0, 1'b0, 48'd0, "reset_hold");
    reset = 1'b1;
    run(0, 0, A, "reset_release");
    run(0, 0, A, "idle");
    req[1] = 1'b1;
    run(1, 1, B, "edit_grant");
    for (int i = 0; i < 9; i++) run(1, 0, B, "edit_steady");
    req[1] = 1'b0;
    run(1, 0, B, "edit_drop");
    pulse_500ms = 1'b1; run(1, 0, B, "edit_tick1");
    pulse_500ms = 1'b0; run(1, 0, B, "edit_gap1");
    run(1, 0, B, "edit_gap1b");
    pulse_500ms = 1'b1; run(1, 0, B, "edit_tick2");
    pulse_500ms = 1'b0; run(1, 0, B, "edit_gap2");
    pulse_500ms = 1'b1; run(0, 1, A, "edit_expire");
    pulse_500ms = 1'b0; run(0, 0, A, "edit_settled");
    req[1] = 1'b1;
    run(1, 1, B, "pre_edit");
    run(1, 0, B, "pre_edit_steady");
    req[2] = 1'b1;
    run(2, 1, C, "preempt");
    req[2] = 1'b0;
    run(2, 0, C, "hold2_enter");
    run(2, 0, C, "hold2_no_preempt");
    pulse_500ms = 1'b1; run(2, 0, C, "hold2_tick1");
    pulse_500ms = 1'b0; run(2, 0, C, "hold2_gap1");
    pulse_500ms = 1'b1; run(2, 0, C, "hold2_tick2");
    pulse_500ms = 1'b0; run(2, 0, C, "hold2_gap2");
    pulse_500ms = 1'b1; run(1, 1, B, "hold2_to_edit");
    pulse_500ms = 1'b0; req[1] = 1'b0;
    run(1, 0, B, "hold1_enter");
    pulse_500ms = 1'b1; run(1, 0, B, "hold1_tick1");
    run(1, 0, B, "hold1_tick2");
    run(0, 1, A, "hold1_expire");
    pulse_500ms = 1'b0;
    src0_d = E; src0_blink = 8'b0000_0011;
    run(0, 0, E, "src_latency");
    pulse_500ms = 1'b1; run(0, 0, EB, "blink_off");
    pulse_500ms = 1'b0; run(0, 0, EB, "blink_hold");
    pulse_500ms = 1'b1; run(0, 0, E, "blink_restore");
    pulse_500ms = 1'b1; run(0, 0, EB, "blink_off2");
    pulse_500ms = 1'b0; run(0, 0, EB, "blink_hold2");
    src2_blink = 8'hFF; req[2] = 1'b1; pulse_500ms = 1'b1;
    run(2, 1, C, "force_visible");
    pulse_500ms = 1'b0; run(2, 0, C, "force_visible_hold");
    pulse_500ms = 1'b1; run(2, 0, CB, "src2_blank");
    pulse_500ms = 1'b0; req[2] = 1'b0;
    run(2, 0, CB, "hold2b_enter");
    pulse_500ms = 1'b1; run(2, 0, C, "hold2b_tick1");
    pulse_500ms = 1'b0; run(2, 0, C, "hold2b_gap");
    pulse_500ms = 1'b1; run(2, 0, CB, "hold2b_tick2");
    pulse_500ms = 1'b0; run(2, 0, CB, "hold2b_gap2");
    pulse_500ms = 1'b1; run(0, 1, E, "hold2b_expire");
    pulse_500ms = 1'b0; src2_blink = 8'h00;
    req = 3'b110;
    run(2, 1, C, "simul_rise");
    req = 3'b000; pulse_500ms = 1'b1;
    run(2, 0, C, "drop_with_tick");
    run(2, 0, C, "drop_tick1");
    run(2, 0, C, "drop_tick2");
    run(0, 1, E, "drop_tick_expire");
    pulse_500ms = 1'b0;
    req[1] = 1'b1;
    run(1, 1, B, "mid_edit");
    req[1] = 1'b0;
    run(1, 0, B, "mid_hold_enter");
    pulse_500ms = 1'b1; run(1, 0, B, "mid_hold_tick");
    pulse_500ms = 1'b0; run(1, 0, B, "mid_hold_cnt2");
    step();
    reset = 1'b0;
    push_now(2'd0, 1'b0, 48'd0, "reset_async");
    run(0, 0, 48'd0, "reset_held");
    reset = 1'b1;
    run(0, 0, E, "post_reset");
    pulse_500ms = 1'b1; run(0, 0, EB, "post_reset_tick1");
    pulse_500ms = 1'b0; run(0, 0, EB, "post_reset_gap");
    pulse_500ms = 1'b1; run(0, 0, E, "post_reset_tick2");
    run(0, 0, EB, "no_return");
    pulse_500ms = 1'b0; run(0, 0, EB, "no_return_final");
    step();
    step();
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/disp_arbiter.md
# disp_arbiter

Shares the 8-digit display driver between three digit sources: running time (src0, default), time/alarm edit view (src1), and alarm notification (src2). Sits between `clock_interface`-class producers and `dspl_drv_8dig`, driving its `d1`..`d8` inputs. It does three things:
- grants the display by fixed priority;
- lingers on a transient source for a programmable number of half-second ticks after it releases;
- applies per-digit blinking to the granted view.

## Interface
Parameters:
- `HOLD_TICKS`, default 6: number of `pulse_500ms` ticks a released src1/src2 keeps the display. Range 1..15.

Ports:
- `clock`, in, 1: system clock, 100 MHz.
- `reset`, in, 1: asynchronous, active-low reset.
- `pulse_500ms`, in, 1: one-cycle tick every 500 ms.
- `req`, in, 3: level requests. `req[0]` is ignored; src0 is always available.
- `src0_d`, `src1_d`, `src2_d`, in, 48 each: eight 6-bit digit codes. Bits [5:0] = d1, …, bits [47:42] = d8.
- `src0_blink`, `src1_blink`, `src2_blink`, in, 8 each: bit k set means digit k+1 blinks.
- `d1`..`d8`, out, 6 each: to the display driver, registered.
- `grant`, out, 2: current source index, 0..2.
- `switch_p`, out, 1: one-cycle pulse on the cycle `grant` changes.

## Operation
Digit code format:
- bit 5 = digit enable.
- bits 4:1 = value.
- bit 0 = decimal point.
- Blanking forces bit 5 to 0 and passes the other bits unchanged.

FSM states: `S_SRC0`, `S_SRC1`, `S_HOLD1`, `S_SRC2`, `S_HOLD2`. Reset state is `S_SRC0`.

Transitions:
- `S_SRC0`: `req[2]` → `S_SRC2`; else `req[1]` → `S_SRC1`.
- `S_SRC1`: `req[2]` → `S_SRC2`; `!req[1]` → `S_HOLD1` and load `hold_cnt = HOLD_TICKS`.
- `S_HOLD1`:
  - `req[2]` → `S_SRC2`.
  - `req[1]` → `S_SRC1`; counter is discarded.
  - Otherwise, decrement on `pulse_500ms`; when the decrement would reach 0 → `S_SRC0`.
- `S_SRC2`: `!req[2]` → `S_HOLD2` and load `hold_cnt = HOLD_TICKS`.
- `S_HOLD2`:
  - `req[2]` → `S_SRC2`.
  - Otherwise, decrement on `pulse_500ms`; on expiry go to `S_SRC1` if `req[1]`, else `S_SRC0`.
  - `req[1]` does not preempt the hold.

Priority and simultaneity rules:
- Priority is src2 > src1 > src0.
- Preemption by a higher request is immediate, regardless of any hold.
- `req[2]` and `req[1]` rising on the same cycle → `S_SRC2`.
- Request drop and `pulse_500ms` on the same cycle: the counter is loaded; the tick is not counted.

Grant mapping:
- `grant` = 0 in `S_SRC0`.
- `grant` = 1 in `S_SRC1` and `S_HOLD1`.
- `grant` = 2 in `S_SRC2` and `S_HOLD2`.

Blink behaviour:
- `blink_on` toggles on every `pulse_500ms`.
- When `grant` changes, `blink_on` is forced to 1 (visible phase). This takes precedence over a coincident tick.
- While `blink_on` = 0, every digit whose bit is set in the granted source's blink mask is blanked.
- Digits are selected from the granted source's live inputs every cycle, not captured at grant time.

Counter width: `hold_cnt` is 4 bits. It never underflows; expiry is checked as `hold_cnt == 1 && pulse_500ms`.

## Timing
- Reset values: `d1`..`d8` = 0 (all blank), `grant` = 0, `switch_p` = 0, `blink_on` = 1, `hold_cnt` = 0.
- Request-to-grant latency: a `req` edge at cycle N updates the state, and `grant` and `switch_p` are seen at cycle N+1.
- `d*` reflect the new source at cycle N+1. `grant` and `d*` are registered together, so they always match.
- Source-data latency: a change on `srcX_d` or `srcX_blink` appears on `d*` one cycle later.
- Hold duration: `S_HOLD*` is left on the cycle after the `HOLD_TICKS`-th `pulse_500ms` following release. Real time is (HOLD_TICKS−1)×500 ms to HOLD_TICKS×500 ms.
- Reset assertion mid-hold or mid-blink clears all state asynchronously. Outputs are blank until the first clock edge after release.

## Structure
Shared package `disp_pkg` holds:
- `digit_t` (`logic [5:0]`);
- `DIG_EN_BIT` = 5;
- `src_e` enum with `SRC_TIME`, `SRC_EDIT`, `SRC_ALARM` = 0..2;
- the FSM state enum `arb_state_e`.

No sub-module. The FSM, hold counter, blink toggle and output mux stay in one module, about 150–200 lines.

## Test plan
- **Reset and default:** release reset with `src0_d` = all digits 6'b100010 → next cycle `d1`..`d8` = 6'b100010, `grant` = 0, `switch_p` = 0.
- **Edit linger:** `HOLD_TICKS` = 3. Raise `req[1]` for 10 cycles, then drop it → `grant` = 1 until the cycle after the 3rd `pulse_500ms`, then 0. `switch_p` fires exactly twice.
- **Preemption:** `grant` = 1 with `req[1]` high; raise `req[2]` → `grant` = 2 next cycle. Drop `req[2]` with `req[1]` still high → hold expires, then `grant` = 1.
- **Blink:** src0 mask 8'b0000_0011, digit codes 6'b100110. Apply `pulse_500ms` → `d1` and `d2` = 6'b000110, `d3` unchanged. Next tick → `d1` and `d2` restored.
- **Grant forces visible phase:** while `blink_on` = 0, raise `req[2]` on the same cycle as `pulse_500ms` → `grant` = 2 and `blink_on` = 1 the next cycle; no digits are blanked.
- **Reset mid-hold:** assert `reset` during `S_HOLD1` with `hold_cnt` = 2 → `grant` = 0 and `d*` = 0 immediately. After release, no spurious return to `grant` = 1.
